// File: rtl/plot_scheduler.sv
// Arbitrates the single VGA pixel write port between a full-screen refresh
// engine (clear, then obstacle render) and one-pixel-at-a-time player plots.
module plot_scheduler #(
    parameter int          SCR_W    = 160,
    parameter int          SCR_H    = 120,
    parameter logic [2:0]  BG_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] obs_mem,
    output logic [7:0] obs_x,
    output logic [6:0] obs_y,
    input  logic       p_req,
    input  logic [7:0] p_x,
    input  logic [6:0] p_y,
    input  logic [2:0] p_color,
    output logic       p_ack,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, PLAYER, CLEAR, RENDER, DRAIN} state_t;

    localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);

    state_t     state_reg;
    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic [2:0] color_reg;
    logic [7:0] obs_x_reg;
    logic [6:0] obs_y_reg;
    logic       plot_reg;
    logic       p_ack_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       dv_reg;
    logic       scan_reg;

    // x_reg/y_reg double as the clear raster counters and, while scanning,
    // as the one-cycle-delayed copy of the obstacle read address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            color_reg <= '0;
            obs_x_reg <= '0;
            obs_y_reg <= '0;
            plot_reg  <= 1'b0;
            p_ack_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dv_reg    <= 1'b0;
            scan_reg  <= 1'b0;
        end else begin
            p_ack_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= CLEAR;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        color_reg <= BG_COLOR;
                        plot_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                    end else if (p_req) begin
                        state_reg <= PLAYER;
                        x_reg     <= p_x;
                        y_reg     <= p_y;
                        color_reg <= p_color;
                        plot_reg  <= 1'b1;
                        p_ack_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                PLAYER: begin
                    state_reg <= IDLE;
                    x_reg     <= '0;
                    y_reg     <= '0;
                    color_reg <= '0;
                    plot_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                CLEAR: begin
                    if (x_reg == X_LAST) begin
                        x_reg <= '0;
                        if (y_reg == Y_LAST) begin
                            state_reg <= RENDER;
                            y_reg     <= '0;
                            plot_reg  <= 1'b0;
                            scan_reg  <= 1'b1;
                            dv_reg    <= 1'b0;
                            obs_x_reg <= '0;
                            obs_y_reg <= '0;
                        end else begin
                            y_reg <= y_reg + 7'd1;
                        end
                    end else begin
                        x_reg <= x_reg + 8'd1;
                    end
                end
                RENDER: begin
                    x_reg  <= obs_x_reg;
                    y_reg  <= obs_y_reg;
                    dv_reg <= 1'b1;
                    if (obs_x_reg == X_LAST) begin
                        obs_x_reg <= '0;
                        if (obs_y_reg == Y_LAST) begin
                            state_reg <= DRAIN;
                            done_reg  <= 1'b1;
                            obs_y_reg <= '0;
                        end else begin
                            obs_y_reg <= obs_y_reg + 7'd1;
                        end
                    end else begin
                        obs_x_reg <= obs_x_reg + 8'd1;
                    end
                end
                DRAIN: begin
                    state_reg <= IDLE;
                    x_reg     <= '0;
                    y_reg     <= '0;
                    color_reg <= '0;
                    busy_reg  <= 1'b0;
                    scan_reg  <= 1'b0;
                    dv_reg    <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // While scanning, the obstacle data arrives straight from the synchronous
    // RAM, so colour and write-enable follow it combinationally.
    assign color = scan_reg ? obs_mem : color_reg;
    assign plot  = scan_reg ? (dv_reg && (obs_mem != BG_COLOR)) : plot_reg;
    assign x     = x_reg;
    assign y     = y_reg;
    assign obs_x = obs_x_reg;
    assign obs_y = obs_y_reg;
    assign p_ack = p_ack_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler: reset, player writes, refresh contents
// and timing, start/p_req contention, mid-refresh reset and ignored start.
module tb_plot_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] obs_mem = 3'b000;
    logic [7:0] obs_x;
    logic [6:0] obs_y;
    logic       p_req;
    logic [7:0] p_x;
    logic [6:0] p_y;
    logic [2:0] p_color;
    logic       p_ack;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    plot_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .obs_mem(obs_mem),
        .obs_x(obs_x), .obs_y(obs_y), .p_req(p_req), .p_x(p_x), .p_y(p_y),
        .p_color(p_color), .p_ack(p_ack), .x(x), .y(y), .color(color),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Obstacle memory: colour 2 at (5,7) and (159,119), background elsewhere.
    always @(posedge clk) begin
        if ((obs_x == 8'd5 && obs_y == 7'd7) || (obs_x == 8'd159 && obs_y == 7'd119))
            obs_mem <= 3'b010;
        else
            obs_mem <= 3'b000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    int          clear_bad, busy_bad, ack_cnt, done_cnt, done_cycle, render_writes, plot_cnt;
    logic [17:0] w1, w2;
    logic [7:0]  ex;
    logic [6:0]  ey;

    initial begin
        reset = 1'b0; start = 1'b0; p_req = 1'b0;
        p_x = '0; p_y = '0; p_color = '0;

        // Reset held two cycles, then idle with no requests
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle_outputs_%0d", i),
                  {6'b0, plot, p_ack, busy, done, x, y, color, obs_x, obs_y}, 32'd0);
            tick();
        end

        // Single player write
        p_req = 1'b1; p_x = 8'd42; p_y = 7'd17; p_color = 3'b100;
        tick();
        check("player_plot", {31'b0, plot}, 32'd1);
        check("player_ack", {31'b0, p_ack}, 32'd1);
        check("player_xyc", {14'b0, x, y, color}, {14'b0, 8'd42, 7'd17, 3'd4});
        check("player_busy", {31'b0, busy}, 32'd1);
        p_req = 1'b0;
        plot_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (plot === 1'b1 || p_ack === 1'b1) plot_cnt++;
        end
        check("player_single_write", plot_cnt, 0);

        // Reset in the middle of a refresh
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4998) tick();
        check("mid_refresh_clearing", {16'b0, plot, x, y}, {16'b0, 1'b1, 8'd38, 7'd31});
        reset = 1'b0;
        tick();
        check("abort_state", {6'b0, plot, p_ack, busy, done, x, y, color, obs_x, obs_y}, 32'd0);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy !== 1'b0 || plot !== 1'b0) done_cnt++;
        end
        check("abort_stays_idle", done_cnt, 0);

        // Full refresh with simultaneous p_req and a second start at cycle 100
        start = 1'b1; p_req = 1'b1; p_x = 8'd10; p_y = 7'd20; p_color = 3'b101;
        tick();
        start = 1'b0;
        clear_bad = 0; busy_bad = 0; ack_cnt = 0; done_cnt = 0; done_cycle = 0;
        render_writes = 0; w1 = '0; w2 = '0;
        for (int c = 1; c <= 38401; c++) begin
            if (busy !== 1'b1) busy_bad++;
            if (p_ack === 1'b1) ack_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cycle = c;
            end
            if (c <= 19200) begin
                ex = 8'((c - 1) % 160);
                ey = 7'((c - 1) / 160);
                if (!(plot === 1'b1 && x === ex && y === ey && color === 3'b000)) clear_bad++;
            end else if (plot === 1'b1) begin
                render_writes++;
                if (render_writes == 1) w1 = {x, y, color};
                if (render_writes == 2) w2 = {x, y, color};
            end
            start = (c == 100);
            tick();
        end
        start = 1'b0;
        check("clear_raster", clear_bad, 0);
        check("busy_through_refresh", busy_bad, 0);
        check("no_ack_during_refresh", ack_cnt, 0);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_cycle, 38401);
        check("render_write_count", render_writes, 2);
        check("render_write_1", {14'b0, w1}, {14'b0, 8'd5, 7'd7, 3'd2});
        check("render_write_2", {14'b0, w2}, {14'b0, 8'd159, 7'd119, 3'd2});
        // Cycle 38402: IDLE, sees the pending request
        check("idle_after_done", {29'b0, busy, plot, done}, 32'd0);
        tick();
        // Cycle 38403: pending player pixel written
        check("deferred_ack", {30'b0, plot, p_ack}, 32'd3);
        check("deferred_xyc", {14'b0, x, y, color}, {14'b0, 8'd10, 7'd20, 3'd5});
        p_req = 1'b0;
        tick();
        check("deferred_done", {30'b0, plot, p_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
